// File: rtl/cpu_sequencer.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with a req/ack memory port.
// Optional performance counters are built when CPU_SEQ_PERF_EN is defined.
module cpu_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [6:0]       i_opcode,
  input  logic             i_branch_taken,
  input  logic             i_mem_ack,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic             o_ir_write,
  output logic             o_reg_write,
  output logic [1:0]       o_wb_sel,
  output logic             o_pc_write,
  output logic             o_pc_sel,
  output logic             o_halted,
  output logic             o_illegal,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_retired,
  output logic [CNT_W-1:0] o_stalls
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t     r_state;
  state_t     w_state_next;
  logic [6:0] r_op;
  logic       r_illegal;
  logic       w_illegal_next;

  // The opcode is captured during DECODE so EXEC/MEM/WB ignore later input changes.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_IDLE;
      r_op      <= 7'd0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_illegal <= w_illegal_next;
      if (r_state == S_DECODE) begin
        r_op <= i_opcode;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_illegal_next = r_illegal;
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_ir_write     = 1'b0;
    o_reg_write    = 1'b0;
    o_wb_sel       = 2'd0;
    o_pc_write     = 1'b0;
    o_pc_sel       = 1'b0;
    o_halted       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_next = S_FETCH;
        end
      end
      S_FETCH: begin
        o_mem_req  = 1'b1;
        o_ir_write = i_mem_ack;
        if (i_mem_ack) begin
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        case (i_opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_JAL: begin
            w_state_next = S_EXEC;
          end
          OP_SYSTEM: begin
            w_state_next   = S_HALT;
            w_illegal_next = 1'b0;
          end
          default: begin
            w_state_next   = S_HALT;
            w_illegal_next = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        case (r_op)
          OP_BRANCH: begin
            o_pc_write   = 1'b1;
            o_pc_sel     = i_branch_taken;
            w_state_next = S_FETCH;
          end
          OP_LOAD, OP_STORE: begin
            w_state_next = S_MEM;
          end
          default: begin
            w_state_next = S_WB;
          end
        endcase
      end
      S_MEM: begin
        o_mem_req = 1'b1;
        o_mem_we  = (r_op == OP_STORE);
        if (i_mem_ack) begin
          if (r_op == OP_STORE) begin
            o_pc_write   = 1'b1;
            w_state_next = S_FETCH;
          end else begin
            w_state_next = S_WB;
          end
        end
      end
      S_WB: begin
        o_reg_write  = 1'b1;
        o_pc_write   = 1'b1;
        o_pc_sel     = (r_op == OP_JAL);
        if (r_op == OP_LOAD) begin
          o_wb_sel = 2'd1;
        end else if (r_op == OP_JAL) begin
          o_wb_sel = 2'd2;
        end
        w_state_next = S_FETCH;
      end
      S_HALT: begin
        o_halted = 1'b1;
        if (i_start) begin
          w_illegal_next = 1'b0;
          w_state_next   = S_FETCH;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign o_illegal = r_illegal;
  assign o_state   = r_state;

`ifdef CPU_SEQ_PERF_EN
  logic [CNT_W-1:0] r_retired;
  logic [CNT_W-1:0] r_stalls;

  // Every retired instruction produces exactly one pc_write, so it doubles as the retire event.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_retired <= '0;
      r_stalls  <= '0;
    end else begin
      r_retired <= r_retired + CNT_W'(o_pc_write);
      r_stalls  <= r_stalls + CNT_W'(o_mem_req & ~i_mem_ack);
    end
  end

  assign o_retired = r_retired;
  assign o_stalls  = r_stalls;
`else
  assign o_retired = '0;
  assign o_stalls  = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed self-checking bench for cpu_sequencer; one task per scenario.
module tb_cpu_sequencer;

`ifdef CPU_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_FENCE = 7'b0001111;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [6:0]  opcode;
  logic        taken;
  logic        ack;
  logic        mem_req;
  logic        mem_we;
  logic        ir_write;
  logic        reg_write;
  logic [1:0]  wb_sel;
  logic        pc_write;
  logic        pc_sel;
  logic        halted;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] retired;
  logic [31:0] stalls;
  logic [12:0] obs;

  int tests = 0;
  int fails = 0;

  cpu_sequencer #(.CNT_W(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst_n),
    .i_start        (start),
    .i_opcode       (opcode),
    .i_branch_taken (taken),
    .i_mem_ack      (ack),
    .o_mem_req      (mem_req),
    .o_mem_we       (mem_we),
    .o_ir_write     (ir_write),
    .o_reg_write    (reg_write),
    .o_wb_sel       (wb_sel),
    .o_pc_write     (pc_write),
    .o_pc_sel       (pc_sel),
    .o_halted       (halted),
    .o_illegal      (illegal),
    .o_state        (state),
    .o_retired      (retired),
    .o_stalls       (stalls)
  );

  // Observation word: {state, mem_req, mem_we, ir_write, reg_write, wb_sel, pc_write, pc_sel, halted, illegal}
  assign obs = {state, mem_req, mem_we, ir_write, reg_write, wb_sel, pc_write, pc_sel, halted, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 1'b0;
    {start, ack, taken, opcode} = 10'd0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    {start, ack, taken, opcode} = {3'b110, OP_R};
    @(posedge clk);
    #1;
    tests++;
    if (obs !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs obs=%b exp=%b", obs, 13'd0);
    end
    tests++;
    if (retired !== 32'd0 || stalls !== 32'd0) begin
      fails++;
      $display("FAIL reset_counters retired=%0d stalls=%0d exp=0/0", retired, stalls);
    end
    rst_n = 1'b1;
    {start, ack, taken, opcode} = 10'd0;
  endtask

  task automatic test_rtype();
    logic [9:0]  stim [5];
    logic [12:0] expv [5];
    stim = '{{3'b100, OP_R}, {3'b010, OP_R}, {3'b010, OP_R}, {3'b010, OP_R}, {3'b010, OP_R}};
    expv = '{{3'd0, 4'b0000, 2'd0, 4'b0000}, {3'd1, 4'b1010, 2'd0, 4'b0000},
             {3'd2, 4'b0000, 2'd0, 4'b0000}, {3'd3, 4'b0000, 2'd0, 4'b0000},
             {3'd5, 4'b0001, 2'd0, 4'b1000}};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      {start, ack, taken, opcode} = stim[i];
      #1;
      tests++;
      if (obs !== expv[i]) begin
        fails++;
        $display("FAIL rtype_cyc%0d obs=%b exp=%b", i, obs, expv[i]);
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if (retired !== (PERF ? 32'd1 : 32'd0)) begin
      fails++;
      $display("FAIL rtype_retired got=%0d exp=%0d", retired, PERF ? 1 : 0);
    end
  endtask

  task automatic test_load_stall();
    logic [9:0]  stim [10];
    logic [12:0] expv [10];
    stim = '{{3'b100, OP_LOAD}, {3'b000, OP_LOAD}, {3'b000, OP_LOAD}, {3'b010, OP_LOAD},
             {3'b000, OP_LOAD}, {3'b000, OP_STORE}, {3'b000, OP_STORE}, {3'b000, OP_STORE},
             {3'b010, OP_STORE}, {3'b000, OP_STORE}};
    expv = '{{3'd0, 4'b0000, 2'd0, 4'b0000}, {3'd1, 4'b1000, 2'd0, 4'b0000},
             {3'd1, 4'b1000, 2'd0, 4'b0000}, {3'd1, 4'b1010, 2'd0, 4'b0000},
             {3'd2, 4'b0000, 2'd0, 4'b0000}, {3'd3, 4'b0000, 2'd0, 4'b0000},
             {3'd4, 4'b1000, 2'd0, 4'b0000}, {3'd4, 4'b1000, 2'd0, 4'b0000},
             {3'd4, 4'b1000, 2'd0, 4'b0000}, {3'd5, 4'b0001, 2'd1, 4'b1000}};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      {start, ack, taken, opcode} = stim[i];
      #1;
      tests++;
      if (obs !== expv[i]) begin
        fails++;
        $display("FAIL load_cyc%0d obs=%b exp=%b", i, obs, expv[i]);
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if (stalls !== (PERF ? 32'd4 : 32'd0)) begin
      fails++;
      $display("FAIL load_stalls got=%0d exp=%0d", stalls, PERF ? 4 : 0);
    end
    tests++;
    if (retired !== (PERF ? 32'd1 : 32'd0)) begin
      fails++;
      $display("FAIL load_retired got=%0d exp=%0d", retired, PERF ? 1 : 0);
    end
  endtask

  task automatic test_back_to_back_branch();
    logic [9:0]  stim [8];
    logic [12:0] expv [8];
    stim = '{{3'b100, OP_BR}, {3'b010, OP_BR}, {3'b010, OP_BR}, {3'b011, OP_BR},
             {3'b010, OP_BR}, {3'b010, OP_BR}, {3'b010, OP_BR}, {3'b000, OP_BR}};
    expv = '{{3'd0, 4'b0000, 2'd0, 4'b0000}, {3'd1, 4'b1010, 2'd0, 4'b0000},
             {3'd2, 4'b0000, 2'd0, 4'b0000}, {3'd3, 4'b0000, 2'd0, 4'b1100},
             {3'd1, 4'b1010, 2'd0, 4'b0000}, {3'd2, 4'b0000, 2'd0, 4'b0000},
             {3'd3, 4'b0000, 2'd0, 4'b1000}, {3'd1, 4'b1000, 2'd0, 4'b0000}};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      {start, ack, taken, opcode} = stim[i];
      #1;
      tests++;
      if (obs !== expv[i]) begin
        fails++;
        $display("FAIL branch_cyc%0d obs=%b exp=%b", i, obs, expv[i]);
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if (retired !== (PERF ? 32'd2 : 32'd0)) begin
      fails++;
      $display("FAIL branch_retired got=%0d exp=%0d", retired, PERF ? 2 : 0);
    end
  endtask

  task automatic test_jal();
    logic [9:0]  stim [6];
    logic [12:0] expv [6];
    stim = '{{3'b100, OP_JAL}, {3'b010, OP_JAL}, {3'b010, OP_JAL}, {3'b010, OP_JAL},
             {3'b010, OP_JAL}, {3'b000, OP_JAL}};
    expv = '{{3'd0, 4'b0000, 2'd0, 4'b0000}, {3'd1, 4'b1010, 2'd0, 4'b0000},
             {3'd2, 4'b0000, 2'd0, 4'b0000}, {3'd3, 4'b0000, 2'd0, 4'b0000},
             {3'd5, 4'b0001, 2'd2, 4'b1100}, {3'd1, 4'b1000, 2'd0, 4'b0000}};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      {start, ack, taken, opcode} = stim[i];
      #1;
      tests++;
      if (obs !== expv[i]) begin
        fails++;
        $display("FAIL jal_cyc%0d obs=%b exp=%b", i, obs, expv[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_store();
    logic [9:0]  stim [6];
    logic [12:0] expv [6];
    stim = '{{3'b100, OP_STORE}, {3'b010, OP_STORE}, {3'b010, OP_STORE}, {3'b000, OP_R},
             {3'b010, OP_LOAD}, {3'b000, OP_LOAD}};
    expv = '{{3'd0, 4'b0000, 2'd0, 4'b0000}, {3'd1, 4'b1010, 2'd0, 4'b0000},
             {3'd2, 4'b0000, 2'd0, 4'b0000}, {3'd3, 4'b0000, 2'd0, 4'b0000},
             {3'd4, 4'b1100, 2'd0, 4'b1000}, {3'd1, 4'b1000, 2'd0, 4'b0000}};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      {start, ack, taken, opcode} = stim[i];
      #1;
      tests++;
      if (obs !== expv[i]) begin
        fails++;
        $display("FAIL store_cyc%0d obs=%b exp=%b", i, obs, expv[i]);
      end
      @(posedge clk);
      #1;
    end
    tests++;
    if (retired !== (PERF ? 32'd1 : 32'd0)) begin
      fails++;
      $display("FAIL store_retired got=%0d exp=%0d", retired, PERF ? 1 : 0);
    end
  endtask

  task automatic test_illegal();
    logic [9:0]  stim [6];
    logic [12:0] expv [6];
    stim = '{{3'b100, OP_FENCE}, {3'b010, OP_FENCE}, {3'b010, OP_FENCE}, {3'b010, OP_FENCE},
             {3'b100, OP_FENCE}, {3'b000, OP_FENCE}};
    expv = '{{3'd0, 4'b0000, 2'd0, 4'b0000}, {3'd1, 4'b1010, 2'd0, 4'b0000},
             {3'd2, 4'b0000, 2'd0, 4'b0000}, {3'd6, 4'b0000, 2'd0, 4'b0011},
             {3'd6, 4'b0000, 2'd0, 4'b0011}, {3'd1, 4'b1000, 2'd0, 4'b0000}};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      {start, ack, taken, opcode} = stim[i];
      #1;
      tests++;
      if (obs !== expv[i]) begin
        fails++;
        $display("FAIL illegal_cyc%0d obs=%b exp=%b", i, obs, expv[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ecall();
    logic [9:0]  stim [5];
    logic [12:0] expv [5];
    stim = '{{3'b100, OP_SYS}, {3'b010, OP_SYS}, {3'b010, OP_SYS}, {3'b010, OP_SYS},
             {3'b010, OP_SYS}};
    expv = '{{3'd0, 4'b0000, 2'd0, 4'b0000}, {3'd1, 4'b1010, 2'd0, 4'b0000},
             {3'd2, 4'b0000, 2'd0, 4'b0000}, {3'd6, 4'b0000, 2'd0, 4'b0010},
             {3'd6, 4'b0000, 2'd0, 4'b0010}};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      {start, ack, taken, opcode} = stim[i];
      #1;
      tests++;
      if (obs !== expv[i]) begin
        fails++;
        $display("FAIL ecall_cyc%0d obs=%b exp=%b", i, obs, expv[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [9:0]  stim [5];
    logic [12:0] expv [5];
    stim = '{{3'b100, OP_LOAD}, {3'b010, OP_LOAD}, {3'b000, OP_LOAD}, {3'b000, OP_LOAD},
             {3'b000, OP_LOAD}};
    expv = '{{3'd0, 4'b0000, 2'd0, 4'b0000}, {3'd1, 4'b1010, 2'd0, 4'b0000},
             {3'd2, 4'b0000, 2'd0, 4'b0000}, {3'd3, 4'b0000, 2'd0, 4'b0000},
             {3'd4, 4'b1000, 2'd0, 4'b0000}};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      {start, ack, taken, opcode} = stim[i];
      #1;
      tests++;
      if (obs !== expv[i]) begin
        fails++;
        $display("FAIL rstmid_cyc%0d obs=%b exp=%b", i, obs, expv[i]);
      end
      if (i < 4) begin
        @(posedge clk);
        #1;
      end
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== 13'd0) begin
      fails++;
      $display("FAIL rstmid_async obs=%b exp=%b", obs, 13'd0);
    end
    tests++;
    if (stalls !== 32'd0 || retired !== 32'd0) begin
      fails++;
      $display("FAIL rstmid_counters retired=%0d stalls=%0d exp=0/0", retired, stalls);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ack   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests++;
      if (obs !== 13'd0) begin
        fails++;
        $display("FAIL rstmid_ackignored_cyc%0d obs=%b exp=%b", i, obs, 13'd0);
      end
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ack   = 1'b0;
    #1;
    tests++;
    if (state !== 3'd1) begin
      fails++;
      $display("FAIL rstmid_restart state=%0d exp=1", state);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    {start, ack, taken, opcode} = 10'd0;
    test_reset();
    test_rtype();
    test_load_stall();
    test_back_to_back_branch();
    test_jal();
    test_store();
    test_illegal();
    test_ecall();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control FSM for the RV32I core: sequences every instruction through fetch, decode, execute, memory and write-back, and drives the strobes that advance the PC, latch the instruction, request memory and fire `regWrite` into the register-file decoder. It owns the shared instruction/data memory port through a req/ack handshake. It stops on `ecall` or an unsupported opcode.

## Interface
- `CNT_W`, 32, width of the performance counters.
- `clk`  in  1  system clock, all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  level; leaves IDLE or HALT and begins fetching.
- `opcode`  in  7  `inst[6:0]` of the latched instruction; valid from DECODE onward.
- `branch_taken`  in  1  ALU compare result; sampled in EXEC for branches only.
- `mem_ack`  in  1  memory completes the current request this cycle.
- `mem_req`  out  1  memory request, held until ack.
- `mem_we`  out  1  write qualifier for `mem_req` (stores only).
- `ir_write`  out  1  instruction register load.
- `reg_write`  out  1  drives the register file's `regWrite`.
- `wb_sel`  out  2  write-back source: 0 ALU, 1 memory, 2 PC+4.
- `pc_write`  out  1  single-cycle PC update strobe.
- `pc_sel`  out  1  0 = PC+4, 1 = branch/jump target.
- `halted`  out  1  FSM is in HALT.
- `illegal`  out  1  sticky; HALT was entered on an unsupported opcode.
- `state`  out  3  current state encoding.
- `retired`  out  CNT_W  instructions retired (feature-dependent).
- `stalls`  out  CNT_W  cycles with `mem_req` high and `mem_ack` low (feature-dependent).

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Code 7 is unreachable and recovers to IDLE.
- IDLE: waits for `start`=1, then goes to FETCH.
- FETCH: `mem_req`=1, `mem_we`=0. `ir_write` = `mem_ack` (Mealy). Moves to DECODE on `mem_ack`, otherwise holds.
- DECODE: classifies `opcode`.
  - `0110011`, `0010011`, `0000011`, `0100011`, `1100011`, `0110111` and `1101111` go to EXEC.
  - `1110011` goes to HALT with `illegal`=0.
  - Anything else goes to HALT with `illegal`=1.
- EXEC:
  - Branch `1100011`: `pc_write`=1, `pc_sel`=`branch_taken`; retires, then FETCH.
  - Load/store: go to MEM.
  - All others: go to WB.
- MEM: `mem_req`=1, `mem_we`=1 for store. Holds until `mem_ack`.
  - Store: `pc_write`=1, `pc_sel`=0 in the ack cycle; retires, then FETCH.
  - Load: goes to WB.
- WB: `reg_write`=1 and `pc_write`=1 for one cycle; retires, then FETCH.
  - `wb_sel`: load=1, JAL=2, else 0.
  - `pc_sel`: JAL=1, else 0.
- HALT: `halted`=1, no strobes. `start`=1 clears `illegal` and goes to FETCH.
- Strobe rules:
  - `pc_write` fires exactly once per retired instruction.
  - `reg_write` fires at most once per instruction, never for branch or store.
  - `rd`=x0 filtering is the register file's job.
- `opcode` is registered internally on entry to EXEC; later changes on the input are ignored until the next DECODE.

## Timing
- Reset (async, `rst`=0): state=IDLE. All outputs are 0 immediately, including `mem_req` mid-handshake; a pending ack is discarded. Counters and `illegal` also clear to 0.
- Cycles per instruction with `mem_ack` arriving in the first request cycle:
  - branch: 3
  - ALU, LUI, JAL, store: 4
  - load: 5
- Each wait cycle on `mem_ack` adds one cycle.
- `mem_ack` outside FETCH/MEM is ignored. `start` is ignored outside IDLE/HALT.
- Counters wrap modulo 2^CNT_W.

## Configuration
- `CPU_SEQ_PERF_EN` defined:
  - `retired` increments on every `pc_write`.
  - `stalls` increments each cycle with `mem_req`=1 and `mem_ack`=0.
- `CPU_SEQ_PERF_EN` not defined: no counter flops are built, and `retired`/`stalls` are tied to 0.

## Test plan
- Reset then `start`=1, R-type `0110011`, `mem_ack` tied high -> states 1,2,3,5. `reg_write`=1 in cycle 4 with `wb_sel`=0, `pc_write`=1, `pc_sel`=0; `retired`=1.
- Load `0000011`, `mem_ack` delayed 2 cycles in FETCH and MEM -> 9 cycles total, `wb_sel`=1 in WB; `stalls`=4 (0 with the macro undefined).
- Branch `1100011` with `branch_taken`=1, then again with 0 -> 3 cycles each, no `reg_write`; `pc_sel`=1 then 0.
- JAL `1101111` -> WB has `reg_write`=1, `wb_sel`=2, `pc_sel`=1.
- Opcode `0001111` -> HALT with `illegal`=1 and `halted`=1. Then `start` -> `illegal`=0 and state=FETCH.
- `rst` pulled low in MEM with `mem_req`=1 -> `mem_req`=0 and state=0 before the next edge; after release, ack is ignored until `start`.
